// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared state encoding and helpers for the Moore sequence
//               detector and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  // Width of the detector state register.
  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  // FILL  : fewer than PAT_W fresh bits collected since the last restart
  // HUNT  : window full, current window does not equal the pattern
  // MATCH : the most recently accepted sample completed the pattern
  localparam logic [STATE_W-1:0] FILL    = 2'd0;
  localparam logic [STATE_W-1:0] HUNT    = 2'd1;
  localparam logic [STATE_W-1:0] MATCH   = 2'd2;
  localparam logic [STATE_W-1:0] ILLEGAL = 2'd3;

  // The unused encoding is folded back onto FILL so a corrupted state
  // register recovers by re-collecting a full window.
  function automatic state_t decode_state(input state_t s);
    return (s == ILLEGAL) ? FILL : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/moore_seq_detector_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. Clear wins over
//               a coincident increment; at all-ones the count holds.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Count events, clear has priority, hold once every bit is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !sat) begin
      r_cnt <= r_cnt + C_CNT_ONE;
    end
  end

  assign cnt = r_cnt;
  assign sat = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/moore_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : moore_seq_detector
// Description : Moore detector that compares a serial bit stream against a
//               runtime-loadable PAT_W-bit pattern. Overlapping or
//               non-overlapping matching is selectable per sample, samples are
//               gated by en, and matches are tallied in a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] PAT_RESET = 4'b1011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // fill counts 0..PAT_W inclusive, so it needs one more code than PAT_W-1.
  localparam int               FILL_W      = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] C_FILL_ONE  = FILL_W'(1);

  state_t            r_state;
  state_t            w_state_n;
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;

  logic [PAT_W-1:0]  w_hist_shift;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_accept;
  logic              w_window_full;
  logic              w_hit;
  logic              w_cnt_inc;

  // A pattern load discards the coincident sample, so it masks en.
  assign w_accept = en & ~pat_load;

  // Window after taking x: oldest bit falls off the MSB, x enters the LSB.
  assign w_hist_shift = (r_hist << 1) | {{(PAT_W-1){1'b0}}, x};

  // Fill advances by one per accepted bit and sticks at PAT_W.
  assign w_fill_inc = (r_fill >= C_FILL_FULL) ? C_FILL_FULL : (r_fill + C_FILL_ONE);

  assign w_window_full = (w_fill_inc == C_FILL_FULL);
  assign w_hit         = w_window_full & (w_hist_shift == r_pat);
  assign w_cnt_inc     = w_accept & w_hit;

  // Pattern register: reloaded on demand, restored to its default on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat <= PAT_RESET;
    end else if (pat_load) begin
      r_pat <= pat_in;
    end
  end

  // Shift/fill datapath; a non-overlapping match throws away the window age
  // so the next match must be built entirely from new bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (pat_load) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_hist <= w_hist_shift;
      r_fill <= (w_hit && !overlap) ? '0 : w_fill_inc;
    end
  end

  // Next-state logic: transitions happen only on accepted samples.
  always_comb begin
    w_state_n = decode_state(r_state);
    if (pat_load) begin
      w_state_n = FILL;
    end else if (en) begin
      if (w_hit) begin
        w_state_n = MATCH;
      end else if (w_window_full) begin
        w_state_n = HUNT;
      end else begin
        w_state_n = FILL;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Moore output: purely a function of the registered state.
  assign y = (r_state == MATCH);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_cnt_inc),
    .clr   (clr_cnt),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_seq_detector
// Description : Self-checking bench for moore_seq_detector. Two instances share
//               all inputs: one with an 8-bit counter, one with a 2-bit counter
//               to reach saturation quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_seq_detector;

  localparam int PAT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             x;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             clr_cnt;

  logic             y_a;
  logic [7:0]       cnt_a;
  logic             sat_a;
  logic             y_b;
  logic [1:0]       cnt_b;
  logic             sat_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: recent fresh bits, pattern, output and counts.
  bit               m_q[$];
  logic [PAT_W-1:0] m_pat;
  bit               m_y;
  int               m_cnt_a;
  int               m_cnt_b;

  always #5 clk = ~clk;

  moore_seq_detector #(.PAT_W(PAT_W), .CNT_W(8), .PAT_RESET(4'b1011)) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
    .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  moore_seq_detector #(.PAT_W(PAT_W), .CNT_W(2), .PAT_RESET(4'b1011)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
    .y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  task automatic model_reset();
    m_q.delete();
    m_pat   = 4'b1011;
    m_y     = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  // Drive one clock of inputs and advance the reference model. A match is
  // "the last PAT_W fresh bits equal the pattern"; non-overlap forgets bits.
  task automatic cycle(input bit e, input bit xi, input bit ov, input bit pl,
                       input logic [PAT_W-1:0] pi, input bit clr);
    bit hit;
    @(negedge clk);
    en = e; x = xi; overlap = ov; pat_load = pl; pat_in = pi; clr_cnt = clr;
    @(posedge clk);
    hit = 1'b0;
    if (reset) begin
      if (pl) begin
        m_pat = pi;
        m_q.delete();
        m_y = 1'b0;
      end else if (e) begin
        m_q.push_back(xi);
        if (m_q.size() > PAT_W) void'(m_q.pop_front());
        if (m_q.size() == PAT_W) begin
          hit = 1'b1;
          for (int i = 0; i < PAT_W; i++)
            if (m_q[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
        end
        m_y = hit;
        if (hit && !ov) m_q.delete();
      end
      if (clr) begin
        m_cnt_a = 0;
        m_cnt_b = 0;
      end else if (hit) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3)   m_cnt_b++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0; x = 1'b0; overlap = 1'b0; pat_load = 1'b0; pat_in = '0; clr_cnt = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 1'b0; x = 1'b0; overlap = 1'b0; pat_load = 1'b0; pat_in = '0; clr_cnt = 1'b0;
    model_reset();
    #1;
    n_vec++; if (y_a !== 1'b0)   begin n_err++; $display("FAIL reset_y_a got %0b want 0", y_a); end
    n_vec++; if (cnt_a !== 8'd0) begin n_err++; $display("FAIL reset_cnt_a got %0d want 0", cnt_a); end
    n_vec++; if (sat_a !== 1'b0) begin n_err++; $display("FAIL reset_sat_a got %0b want 0", sat_a); end
    n_vec++; if (cnt_b !== 2'd0) begin n_err++; $display("FAIL reset_cnt_b got %0d want 0", cnt_b); end
    n_vec++; if (sat_b !== 1'b0) begin n_err++; $display("FAIL reset_sat_b got %0b want 0", sat_b); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] stream = 7'b1011011;   // MSB sent first
    logic [6:0] exp_y  = 7'b0001001;   // MSB is sample 1
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      cycle(1'b1, stream[i], 1'b1, 1'b0, '0, 1'b0);
      n_vec++;
      if (y_a !== exp_y[i] || y_a !== m_y) begin
        n_err++; $display("FAIL overlap_y sample %0d got %0b want %0b", 7 - i, y_a, exp_y[i]);
      end
    end
    n_vec++; if (cnt_a !== 8'd2) begin n_err++; $display("FAIL overlap_cnt got %0d want 2", cnt_a); end
    // All-ones pattern, five ones: matches on samples 4 and 5.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    n_vec++; if (cnt_a !== 8'd2) begin n_err++; $display("FAIL overlap_1111_cnt got %0d want 2", cnt_a); end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] stream = 7'b1011011;
    logic [6:0] exp_y  = 7'b0001000;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      cycle(1'b1, stream[i], 1'b0, 1'b0, '0, 1'b0);
      n_vec++;
      if (y_a !== exp_y[i] || y_a !== m_y) begin
        n_err++; $display("FAIL nonoverlap_y sample %0d got %0b want %0b", 7 - i, y_a, exp_y[i]);
      end
    end
    n_vec++; if (cnt_a !== 8'd1) begin n_err++; $display("FAIL nonoverlap_cnt got %0d want 1", cnt_a); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (cnt_a !== 8'd1) begin n_err++; $display("FAIL nonoverlap_1111_cnt got %0d want 1", cnt_a); end
  endtask

  task automatic test_stall();
    logic [3:0] stream = 4'b1011;
    do_reset();
    for (int i = 3; i >= 0; i--) cycle(1'b1, stream[i], 1'b1, 1'b0, '0, 1'b0);
    n_vec++; if (y_a !== 1'b1) begin n_err++; $display("FAIL stall_match_y got %0b want 1", y_a); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, '0, 1'b0);
      n_vec++; if (y_a !== 1'b1) begin n_err++; $display("FAIL stall_hold_y cycle %0d got %0b want 1", i, y_a); end
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    n_vec++; if (y_a !== 1'b0)   begin n_err++; $display("FAIL stall_drop_y got %0b want 0", y_a); end
    n_vec++; if (cnt_a !== 8'd1) begin n_err++; $display("FAIL stall_cnt got %0d want 1", cnt_a); end
  endtask

  task automatic test_pat_load();
    logic [2:0] pre  = 3'b101;
    logic [3:0] post = 4'b0110;
    logic [3:0] exp  = 4'b0001;
    do_reset();
    for (int i = 2; i >= 0; i--) cycle(1'b1, pre[i], 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    n_vec++; if (y_a !== 1'b0) begin n_err++; $display("FAIL patload_y got %0b want 0", y_a); end
    for (int i = 3; i >= 0; i--) begin
      cycle(1'b1, post[i], 1'b1, 1'b0, '0, 1'b0);
      n_vec++;
      if (y_a !== exp[i] || y_a !== m_y) begin
        n_err++; $display("FAIL patload_post_y bit %0d got %0b want %0b", 4 - i, y_a, exp[i]);
      end
    end
    n_vec++; if (cnt_a !== 8'd1) begin n_err++; $display("FAIL patload_cnt got %0d want 1", cnt_a); end
  endtask

  task automatic test_saturation();
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      int k;
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      k = (i >= 4) ? i - 3 : 0;
      n_vec++;
      if (cnt_b !== 2'((k > 3) ? 3 : k)) begin
        n_err++; $display("FAIL sat_cnt_b sample %0d got %0d want %0d", i, cnt_b, (k > 3) ? 3 : k);
      end
      n_vec++;
      if (sat_b !== (k >= 3)) begin
        n_err++; $display("FAIL sat_flag_b sample %0d got %0b want %0b", i, sat_b, (k >= 3));
      end
    end
    n_vec++; if (cnt_a !== 8'd5) begin n_err++; $display("FAIL sat_cnt_a got %0d want 5", cnt_a); end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    n_vec++; if (cnt_a !== 8'd0) begin n_err++; $display("FAIL clr_cnt_a got %0d want 0", cnt_a); end
    n_vec++; if (cnt_b !== 2'd0) begin n_err++; $display("FAIL clr_cnt_b got %0d want 0", cnt_b); end
    n_vec++; if (y_a !== 1'b1)   begin n_err++; $display("FAIL clr_y got %0b want 1", y_a); end
  endtask

  task automatic test_async_reset();
    logic [3:0] stream = 4'b1011;
    logic [3:0] exp    = 4'b0001;
    do_reset();
    for (int i = 3; i >= 0; i--) cycle(1'b1, stream[i], 1'b1, 1'b0, '0, 1'b0);
    n_vec++; if (y_a !== 1'b1) begin n_err++; $display("FAIL areset_pre_y got %0b want 1", y_a); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_vec++; if (y_a !== 1'b0)   begin n_err++; $display("FAIL areset_y got %0b want 0", y_a); end
    n_vec++; if (cnt_a !== 8'd0) begin n_err++; $display("FAIL areset_cnt got %0d want 0", cnt_a); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      cycle(1'b1, stream[i], 1'b1, 1'b0, '0, 1'b0);
      n_vec++;
      if (y_a !== exp[i]) begin
        n_err++; $display("FAIL areset_redetect_y bit %0d got %0b want %0b", 4 - i, y_a, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit pl  = ($urandom_range(0, 63) == 0);
      bit clr = ($urandom_range(0, 49) == 0);
      bit e   = ($urandom_range(0, 4) != 0);
      bit ov  = ($urandom_range(0, 3) != 0);
      cycle(e, 1'($urandom_range(0, 1)), ov, pl, 4'($urandom_range(0, 15)), clr);
      n_vec++;
      if (y_a !== m_y || y_b !== m_y) begin
        n_err++; $display("FAIL rand_y cycle %0d got %0b/%0b want %0b", i, y_a, y_b, m_y);
      end
      n_vec++;
      if (cnt_a !== 8'(m_cnt_a) || sat_a !== (m_cnt_a == 255)) begin
        n_err++; $display("FAIL rand_cnt_a cycle %0d got %0d want %0d", i, cnt_a, m_cnt_a);
      end
      n_vec++;
      if (cnt_b !== 2'(m_cnt_b) || sat_b !== (m_cnt_b == 3)) begin
        n_err++; $display("FAIL rand_cnt_b cycle %0d got %0d sat %0b want %0d", i, cnt_b, sat_b, m_cnt_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_stall();
    test_pat_load();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
